sram_wb_bridge: RTL and testbench
=================================

# sram_wb_bridge

Wishbone-classic responder that turns 32-bit word accesses from the SERV data/instruction bus into sequences of byte-wide accesses driven into the `sram_rw` external-SRAM port. It is the initiator for `sram_rw`: it generates `read`/`write`/`addr`/`wdata` one byte per clock and reassembles the registered read bytes into a word. It sits between the CPU bus arbiter and `sram_rw`.

## Interface
- `SRAM_AW`, 14: SRAM byte-address width. The word address is `SRAM_AW-2` bits.
- `clk_i` in 1: clock, shared with `sram_rw`.
- `rst_i` in 1: reset, asynchronous, active-high.
- `wb_cyc_i` in 1: bus cycle valid.
- `wb_stb_i` in 1: strobe. A request is `cyc & stb` in IDLE.
- `wb_we_i` in 1: 1 = write.
- `wb_adr_i` in `SRAM_AW-2`: word address.
- `wb_sel_i` in 4: byte enables, writes only.
- `wb_dat_i` in 32: write data.
- `wb_dat_o` out 32: read data, registered.
- `wb_ack_o` out 1: one-cycle completion pulse.
- `sram_read_o` out 1: to `sram_rw` `read_i`.
- `sram_write_o` out 1: to `sram_rw` `write_i`.
- `sram_addr_o` out `SRAM_AW`: byte address.
- `sram_wdata_o` out 8: write byte.
- `sram_rdata_i` in 8: from `sram_rw` `rdata_o`. Valid the cycle after the matching `sram_read_o` cycle.

## Operation
- **States:** IDLE, READ, DRAIN, WRITE, ACK.
- **Lane counter:** 2 bits. Byte lane k maps to address `{wb_adr_i, k}` and data bits `[8k+7:8k]` (little-endian).
- **IDLE:**
  - Request with `we=0` goes to READ; with `we=1` goes to WRITE. The lane counter is set to 0.
  - The address, `sel` and write data are latched at the accept edge.
  - Later changes on the bus are ignored until ACK.
- **READ:**
  - `sram_read_o=1` and `sram_addr_o={adr_q, cnt}` each cycle; the counter increments.
  - From the second READ cycle on, `sram_rdata_i` is stored into lane `cnt-1`.
  - After lane 3 is issued, go to DRAIN.
- **DRAIN:** store `sram_rdata_i` into lane 3, then go to ACK.
- **WRITE:**
  - Each cycle `sram_write_o=sel_q[cnt]`, `sram_wdata_o=dat_q` lane `cnt`, and the address is as in READ.
  - After lane 3, go to ACK.
- **ACK:** `wb_ack_o=1` for exactly one cycle, then IDLE. A request present during ACK is not accepted.
- **Mutual exclusion:** `sram_read_o` and `sram_write_o` are never both 1. Outside READ/WRITE both are 0, and address/wdata are 0.
- **`wb_dat_o`:** holds the last completed read word and is unchanged by writes.
- **Abort:** if `wb_cyc_i` falls during READ, DRAIN or WRITE, go to IDLE at the next edge.
  - No further SRAM strobes and no ack.
  - Bytes already written remain written.
  - `wb_dat_o` is not updated.
- **Reset mid-operation:** state goes to IDLE immediately; all outputs go to 0.

## Timing
- Reset values: `wb_ack_o=0`, `wb_dat_o=0`, `sram_read_o=0`, `sram_write_o=0`, `sram_addr_o=0`, `sram_wdata_o=0`.
- Request cycle is c0 (accepted at its closing edge).
- **Read:** `sram_read_o` high c1–c4, capture at the edges ending c2–c5, `wb_ack_o` in c6 with `wb_dat_o` valid. Latency is 6 cycles.
- **Write:** strobe slots c1–c4, `wb_ack_o` in c5. Latency is 5 cycles.
- Back-to-back: the next request is accepted no earlier than the cycle after ACK.

## Configuration
- **`SRAM_WB_SEL_SKIP_EN` defined:**
  - WRITE visits only lanes with `sel_q` set, in ascending order, one cycle each.
  - `sel=0000` goes straight to ACK in c1.
  - Write latency is popcount(sel)+1.
- **Not defined:** all four lanes are always visited and unselected lanes have `sram_write_o=0`.
- Reads are identical in both builds.

## Structure
- **Package `sram_wb_pkg`:**
  - State enum `sram_wb_state_e`.
  - `BYTES_PER_WORD=4`.
  - `LANE_W=2`.
- No sub-module: lane select and next-lane logic are inline. The sel-skip next-lane function lives in the package.

## Test plan
- **Read:** preload SRAM addresses 0x010–0x013 = 0x11,0x22,0x33,0x44; read word 0x004 -> `sram_read_o` high c1–c4, ack in c6, `wb_dat_o=0x44332211`.
- **Partial write:** write `adr=0x005`, `dat=0xA1B2C3D4`, `sel=0101` -> bytes 0x014=0xD4 and 0x016=0xB2 written, 0x015 and 0x017 unchanged, ack in c5 (default build).
- **Skip build:** with `SRAM_WB_SEL_SKIP_EN`, same write -> exactly 2 write cycles, ack in c3; `sel=0000` -> no strobes, ack in c1.
- **Back-to-back:** write then read of the same word, `stb` held -> the second request is accepted only after the ack cycle; read returns the written value.
- **Abort:** drop `wb_cyc_i` after the second WRITE cycle -> only lanes 0–1 written, no ack, IDLE; a subsequent read is correct.
- **Reset:** assert `rst_i` in c3 of a read -> all outputs 0 asynchronously; after release, a new read completes normally.

Source files
------------

// File: rtl/sram_wb_pkg.sv
// rtl/sram_wb_pkg.sv - shared types, constants and lane helper for sram_wb_bridge
//
// Contents:
//   sram_wb_state_e : bridge FSM states
//   BYTES_PER_WORD  : byte lanes per Wishbone word
//   LANE_W          : lane counter width
//   sel_next_lane() : lowest selected lane at or above a start lane, used only
//                     when SRAM_WB_SEL_SKIP_EN is defined
package sram_wb_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int LANE_W         = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_WRITE = 3'd3,
    ST_ACK   = 3'd4
  } sram_wb_state_e;

  // Returns {found, lane}. The start value is one bit wider than a lane so
  // that "one past lane 3" can be expressed and yields found=0.
  function automatic logic [LANE_W:0] sel_next_lane(
    input logic [BYTES_PER_WORD-1:0] sel,
    input logic [LANE_W:0]           start
  );
    logic [LANE_W:0] res;
    res = '0;
    for (int k = BYTES_PER_WORD - 1; k >= 0; k--) begin
      if (k >= int'(start) && sel[k]) begin
        res = {1'b1, k[LANE_W-1:0]};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/sram_wb_bridge.sv
// rtl/sram_wb_bridge.sv - Wishbone-classic word responder driving a byte-wide SRAM port
//
// Ports:
//   clk_i, rst_i          : clock, asynchronous active-high reset
//   wb_cyc_i, wb_stb_i    : bus cycle / strobe; a request is cyc & stb in IDLE
//   wb_we_i               : 1 = write
//   wb_adr_i [SRAM_AW-2]  : word address
//   wb_sel_i [4]          : byte enables (writes only)
//   wb_dat_i [32]         : write data
//   wb_dat_o [32]         : last completed read word (registered)
//   wb_ack_o              : one-cycle completion pulse
//   sram_read_o/_write_o  : byte strobes to sram_rw
//   sram_addr_o [SRAM_AW] : byte address {word address, lane}
//   sram_wdata_o [8]      : write byte
//   sram_rdata_i [8]      : read byte, valid the cycle after its read strobe
//
// Build option: SRAM_WB_SEL_SKIP_EN - writes visit only the selected lanes.
module sram_wb_bridge
  import sram_wb_pkg::*;
#(
  parameter int SRAM_AW = 14
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               wb_cyc_i,
  input  logic               wb_stb_i,
  input  logic               wb_we_i,
  input  logic [SRAM_AW-3:0] wb_adr_i,
  input  logic [3:0]         wb_sel_i,
  input  logic [31:0]        wb_dat_i,
  output logic [31:0]        wb_dat_o,
  output logic               wb_ack_o,
  output logic               sram_read_o,
  output logic               sram_write_o,
  output logic [SRAM_AW-1:0] sram_addr_o,
  output logic [7:0]         sram_wdata_o,
  input  logic [7:0]         sram_rdata_i
);

  sram_wb_state_e     state_q, state_d;
  logic [LANE_W-1:0]  cnt_q, cnt_d;
  logic [SRAM_AW-3:0] adr_q;
  logic [3:0]         sel_q;
  logic [31:0]        dat_q;
  logic [23:0]        rd_q;     // lanes 0..2; lane 3 goes straight to wb_dat_o
  logic               req;
  logic               in_read, in_write;

  assign req = wb_cyc_i & wb_stb_i;

`ifdef SRAM_WB_SEL_SKIP_EN
  logic [LANE_W:0] first_lane, next_lane;
  assign first_lane = sel_next_lane(wb_sel_i, '0);
  assign next_lane  = sel_next_lane(sel_q, {1'b0, cnt_q} + 3'd1);
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          cnt_d = '0;
          if (!wb_we_i) begin
            state_d = ST_READ;
          end else begin
`ifdef SRAM_WB_SEL_SKIP_EN
            if (first_lane[LANE_W]) begin
              state_d = ST_WRITE;
              cnt_d   = first_lane[LANE_W-1:0];
            end else begin
              state_d = ST_ACK;
            end
`else
            state_d = ST_WRITE;
`endif
          end
        end
      end
      ST_READ: begin
        if (!wb_cyc_i) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        state_d = wb_cyc_i ? ST_ACK : ST_IDLE;
      end
      ST_WRITE: begin
        if (!wb_cyc_i) begin
          state_d = ST_IDLE;
        end else begin
`ifdef SRAM_WB_SEL_SKIP_EN
          if (next_lane[LANE_W]) cnt_d = next_lane[LANE_W-1:0];
          else                   state_d = ST_ACK;
`else
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = ST_ACK;
`endif
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobes are gated by cyc so a falling cyc suppresses the slot it
  // falls in, not just the ones after the next edge.
  assign in_read      = (state_q == ST_READ);
  assign in_write     = (state_q == ST_WRITE);
  assign sram_read_o  = in_read & wb_cyc_i;
  assign sram_write_o = in_write & wb_cyc_i & sel_q[cnt_q];
  assign sram_addr_o  = (in_read | in_write) ? {adr_q, cnt_q} : '0;
  assign sram_wdata_o = in_write ? dat_q[{cnt_q, 3'b000} +: 8] : '0;
  assign wb_ack_o     = (state_q == ST_ACK);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      adr_q    <= '0;
      sel_q    <= '0;
      dat_q    <= '0;
      rd_q     <= '0;
      wb_dat_o <= '0;
    end else begin
      if (state_q == ST_IDLE && req) begin
        adr_q <= wb_adr_i;
        sel_q <= wb_sel_i;
        dat_q <= wb_dat_i;
      end
      // Read data lags its strobe by one cycle, so lane cnt-1 arrives now.
      if (in_read) begin
        case (cnt_q)
          2'd1:    rd_q[7:0]   <= sram_rdata_i;
          2'd2:    rd_q[15:8]  <= sram_rdata_i;
          2'd3:    rd_q[23:16] <= sram_rdata_i;
          default: ;
        endcase
      end
      // Publish only a complete word; an aborted read leaves wb_dat_o alone.
      if (state_q == ST_DRAIN && wb_cyc_i) begin
        wb_dat_o <= {sram_rdata_i, rd_q};
      end
    end
  end

endmodule

// File: tb/tb_sram_wb_bridge.sv
// tb/tb_sram_wb_bridge.sv - scoreboard bench for sram_wb_bridge with a byte SRAM model
module tb_sram_wb_bridge;

  localparam int AW = 14;
`ifdef SRAM_WB_SEL_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [AW-3:0] adr = '0;
  logic [3:0]    sel = '0;
  logic [31:0]   dat = '0;
  logic [31:0]   dat_o;
  logic          ack, s_rd, s_wr;
  logic [AW-1:0] s_addr;
  logic [7:0]    s_wdata, s_rdata;

  always #5 clk = ~clk;

  sram_wb_bridge #(.SRAM_AW(AW)) dut (
    .clk_i(clk), .rst_i(rst),
    .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_sel_i(sel), .wb_dat_i(dat),
    .wb_dat_o(dat_o), .wb_ack_o(ack),
    .sram_read_o(s_rd), .sram_write_o(s_wr),
    .sram_addr_o(s_addr), .sram_wdata_o(s_wdata), .sram_rdata_i(s_rdata)
  );

  function automatic logic [7:0] pre_byte(input int a);
    if (a >= 16 && a < 20) return 8'(8'h11 * (a - 15));
    if (a >= 20 && a < 24) return 8'(8'h90 + (a - 20));
    if (a >= 24 && a < 28) return 8'(8'hE0 + (a - 24));
    return 8'h00;
  endfunction

  // Byte SRAM with a registered read port, preloaded during the first reset.
  logic [7:0] sram [0:(1<<AW)-1];
  bit         preloaded = 1'b0;
  always @(posedge clk) begin
    if (rst && !preloaded) begin
      for (int k = 16; k < 28; k++) sram[k] <= pre_byte(k);
      preloaded <= 1'b1;
    end else begin
      if (s_wr) sram[s_addr] <= s_wdata;
      if (s_rd) s_rdata <= sram[s_addr];
    end
  end

  logic [7:0]  ref_mem [0:(1<<AW)-1];
  logic [31:0] exp_q [$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  int a_ack, a_nrd, a_nwr, a_first, a_last;
  logic [AW-1:0] a_addr;

  // One Wishbone access; observations indexed by cycle, c0 = request cycle.
  task automatic access(input bit w, input logic [AW-3:0] a, input logic [3:0] s,
                        input logic [31:0] d, input bit keep);
    logic [1:0] lk;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat = d;
    if (!w) begin
      exp_q.push_back({ref_mem[{a, 2'd3}], ref_mem[{a, 2'd2}], ref_mem[{a, 2'd1}], ref_mem[{a, 2'd0}]});
    end else begin
      for (int k = 0; k < 4; k++) begin
        lk = k[1:0];
        if (s[k]) ref_mem[{a, lk}] = d[8*k +: 8];
      end
    end
    a_ack = -1; a_nrd = 0; a_nwr = 0; a_first = -1; a_last = -1; a_addr = '0;
    for (int n = 0; n < 20; n++) begin
      if (n > 0) begin @(posedge clk); #1; end
      @(negedge clk);
      if (s_rd) begin
        if (a_first < 0) begin a_first = n; a_addr = s_addr; end
        a_last = n;
        a_nrd++;
      end
      if (s_wr) a_nwr++;
      if (ack) begin
        a_ack = n;
        if (!w) begin
          if (exp_q.size() > 0) check_eq("rd_data", dat_o, exp_q.pop_front());
          else                  check_eq("sb_empty", 32'd1, 32'd0);
        end
        break;
      end
    end
    if (!keep) begin
      @(posedge clk); #1;
      cyc = 1'b0; stb = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int nwr, nack;
    for (int k = 0; k < (1<<AW); k++) ref_mem[k] = pre_byte(k);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ack", {31'd0, ack}, 32'd0);
    check_eq("rst_dat", dat_o, 32'd0);
    check_eq("rst_rd", {31'd0, s_rd}, 32'd0);
    check_eq("rst_wr", {31'd0, s_wr}, 32'd0);
    check_eq("rst_addr", 32'(s_addr), 32'd0);
    check_eq("rst_wdata", 32'(s_wdata), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Read word 4 (bytes 0x010..0x013).
    access(1'b0, 12'h004, 4'h0, 32'h0, 1'b0);
    check_eq("rd_ack_cyc", a_ack, 6);
    check_eq("rd_strobes", a_nrd, 4);
    check_eq("rd_first", a_first, 1);
    check_eq("rd_last", a_last, 4);
    check_eq("rd_addr0", 32'(a_addr), 32'h010);
    check_eq("rd_no_wr", a_nwr, 0);

    // Partial write sel=0101.
    access(1'b1, 12'h005, 4'b0101, 32'hA1B2C3D4, 1'b0);
    check_eq("pw_ack_cyc", a_ack, SKIP ? 3 : 5);
    check_eq("pw_strobes", a_nwr, 2);
    check_eq("pw_b14", 32'(sram[14'h014]), 32'hD4);
    check_eq("pw_b15", 32'(sram[14'h015]), 32'h91);
    check_eq("pw_b16", 32'(sram[14'h016]), 32'hB2);
    check_eq("pw_b17", 32'(sram[14'h017]), 32'h93);

    // Empty byte mask.
    access(1'b1, 12'h005, 4'b0000, 32'hFFFFFFFF, 1'b0);
    check_eq("w0_ack_cyc", a_ack, SKIP ? 1 : 5);
    check_eq("w0_strobes", a_nwr, 0);
    access(1'b0, 12'h005, 4'h0, 32'h0, 1'b0);

    // Back-to-back write then read, request held across the ack.
    access(1'b1, 12'h007, 4'b1111, 32'hCAFEF00D, 1'b1);
    check_eq("bb_w_ack_cyc", a_ack, 5);
    access(1'b0, 12'h007, 4'h0, 32'h0, 1'b0);
    check_eq("bb_r_first", a_first, 1);
    check_eq("bb_r_no_wr", a_nwr, 0);
    check_eq("bb_r_ack_cyc", a_ack, 6);

    // Abort a full write after its second strobe slot.
    nwr = 0; nack = 0;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 12'h006; sel = 4'hF; dat = 32'h55667788;
    for (int n = 0; n < 10; n++) begin
      if (n > 0) begin @(posedge clk); #1; end
      if (n == 3) begin cyc = 1'b0; stb = 1'b0; end
      @(negedge clk);
      if (s_wr) nwr++;
      if (ack) nack++;
    end
    ref_mem[14'h018] = 8'h88;
    ref_mem[14'h019] = 8'h77;
    check_eq("ab_strobes", nwr, 2);
    check_eq("ab_no_ack", nack, 0);
    check_eq("ab_b19", 32'(sram[14'h019]), 32'h77);
    check_eq("ab_b1a", 32'(sram[14'h01A]), 32'hE2);
    access(1'b0, 12'h006, 4'h0, 32'h0, 1'b0);
    check_eq("ab_r_ack_cyc", a_ack, 6);

    // Asynchronous reset in c3 of a read.
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 12'h004;
    repeat (3) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    check_eq("mr_rd", {31'd0, s_rd}, 32'd0);
    check_eq("mr_addr", 32'(s_addr), 32'd0);
    check_eq("mr_ack", {31'd0, ack}, 32'd0);
    check_eq("mr_dat", dat_o, 32'd0);
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    access(1'b0, 12'h004, 4'h0, 32'h0, 1'b0);
    check_eq("mr_r_ack_cyc", a_ack, 6);
    check_eq("sb_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
